cordic_engine: RTL and testbench

- Synthesizable, parametrised fixed-point iterative CORDIC in rotation mode.
- Successor to the floating-point exp/rotation block; selectable circular mode (cos/sin) or hyperbolic mode (cosh/sinh/exp) per request.
- Uses start/busy/done handshake.
- Sits between the angle memory front-end and the result write-back memory; one request in flight at a time.

---
 rtl/cordic_pkg.sv | 33 +++
 rtl/cordic_angle_rom.sv | 40 ++++
 rtl/cordic_engine.sv | 169 ++++++++++++++++
 tb/tb_cordic_engine.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants and elaboration-time helpers for the CORDIC engine
package cordic_pkg;

   localparam logic MODE_CIRC = 1'b0;
   localparam logic MODE_HYP  = 1'b1;

   localparam real K_INV_CIRC = 0.6072529350;
   localparam real K_INV_HYP  = 1.2074970677;

   localparam real RANGE_CIRC = 1.5;
   localparam real RANGE_HYP  = 1.0;

   // Hyperbolic indices that must run twice for the series to converge
   localparam int HYP_REP0 = 4;
   localparam int HYP_REP1 = 13;

   function automatic longint quantize(input real v, input int fb);
      real s;
      s = v * (2.0 ** fb);
      if (s >= 0.0)
         return longint'($rtoi(s + 0.5));
      else
         return -longint'($rtoi(0.5 - s));
   endfunction

   function automatic int n_steps(input logic m, input int iter);
      if (m == MODE_HYP)
         return iter + ((iter >= HYP_REP0) ? 1 : 0) + ((iter >= HYP_REP1) ? 1 : 0);
      else
         return iter;
   endfunction

endpackage

// File: rtl/cordic_angle_rom.sv
// rtl/cordic_angle_rom.sv - atan/atanh(2^-i) lookup quantized to the internal datapath width
module cordic_angle_rom
   import cordic_pkg::*;
#(
   parameter int W     = 16,
   parameter int ITER  = 14,
   parameter int GUARD = 3,
   parameter int IW    = 4
)(
   input  logic                        mode,
   input  logic [IW-1:0]               idx,
   output logic signed [W+GUARD-1:0]   angle
);

   localparam int WI = W + GUARD;
   localparam int FB = W - 3 + GUARD;

   logic signed [WI-1:0] circ_tab [2**IW];
   logic signed [WI-1:0] hyp_tab  [2**IW];

   // atanh(1) diverges, so hyperbolic entry 0 stays zero along with unused slots
   for (genvar g = 0; g < 2**IW; g++) begin : g_tab
      localparam real T = 1.0 / (2.0 ** g);
      if (g > ITER) begin : g_unused
         assign circ_tab[g] = '0;
         assign hyp_tab[g]  = '0;
      end else if (g == 0) begin : g_first
         assign circ_tab[g] = WI'(quantize($atan(T), FB));
         assign hyp_tab[g]  = '0;
      end else begin : g_used
         assign circ_tab[g] = WI'(quantize($atan(T), FB));
         assign hyp_tab[g]  = WI'(quantize($atanh(T), FB));
      end
   end

   always_comb begin
      angle = (mode == MODE_HYP) ? hyp_tab[idx] : circ_tab[idx];
   end

endmodule

// File: rtl/cordic_engine.sv
// rtl/cordic_engine.sv - iterative rotation-mode CORDIC, circular or hyperbolic per request
// Optional sat output port enabled by defining CORDIC_SAT_FLAG_EN.
module cordic_engine
   import cordic_pkg::*;
#(
   parameter int W     = 16,
   parameter int ITER  = 14,
   parameter int GUARD = 3
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mode,
   input  logic [W-1:0]  angle,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [W-1:0]  x_out,
   output logic [W-1:0]  y_out,
   output logic [W-1:0]  sum_out
`ifdef CORDIC_SAT_FLAG_EN
   ,
   output logic          sat
`endif
);

   localparam int WI      = W + GUARD;
   localparam int FB      = W - 3 + GUARD;
   localparam int IW      = $clog2(ITER + 1);
   localparam int CW      = $clog2(ITER + 3);
   localparam int NS_CIRC = n_steps(MODE_CIRC, ITER);
   localparam int NS_HYP  = n_steps(MODE_HYP, ITER);
   localparam logic signed [WI:0] HALF = (WI+1)'(2 ** (GUARD - 1));

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   logic [1:0]           state;
   logic                 mode_r, rep, err_r;
   logic [IW-1:0]        idx;
   logic [CW-1:0]        cnt;
   logic signed [WI-1:0] x, y, z;
   logic signed [WI-1:0] x0_circ, x0_hyp, rom_angle;
   logic signed [WI-1:0] xs, ys, x_step, y_step, z_step;
   logic [W:0]           lim_circ, lim_hyp, abs_angle;
   logic signed [W:0]    angle_ext;
   logic                 in_range, d_pos, last_step, rep_now;
   logic signed [WI:0]   x_rnd_full, y_rnd_full;
   logic [W:0]           x_rnd, y_rnd, sum_full;
   logic [W-1:0]         x_sat, y_sat, sum_sat;
   logic                 sat_any;

   assign x0_circ  = WI'(quantize(K_INV_CIRC, FB));
   assign x0_hyp   = WI'(quantize(K_INV_HYP, FB));
   assign lim_circ = (W+1)'(quantize(RANGE_CIRC, W - 3));
   assign lim_hyp  = (W+1)'(quantize(RANGE_HYP, W - 3));

   // Extra bit lets |-2^(W-1)| be represented so it fails the range compare
   assign angle_ext = {angle[W-1], angle};
   assign abs_angle = angle[W-1] ? -angle_ext : angle_ext;
   assign in_range  = abs_angle <= ((mode == MODE_HYP) ? lim_hyp : lim_circ);

   cordic_angle_rom #(.W(W), .ITER(ITER), .GUARD(GUARD), .IW(IW)) u_rom (
      .mode  (mode_r),
      .idx   (idx),
      .angle (rom_angle)
   );

   assign xs     = x >>> idx;
   assign ys     = y >>> idx;
   assign d_pos  = ~z[WI-1];
   assign x_step = (d_pos ^ (mode_r == MODE_HYP)) ? x - ys : x + ys;
   assign y_step = d_pos ? y + xs : y - xs;
   assign z_step = d_pos ? z - rom_angle : z + rom_angle;

   assign last_step = (cnt == CW'(((mode_r == MODE_HYP) ? NS_HYP : NS_CIRC) - 1));
   assign rep_now   = (mode_r == MODE_HYP) && !rep &&
                      ((idx == IW'(HYP_REP0)) || (idx == IW'(HYP_REP1)));

   function automatic logic [W-1:0] sat_w(input logic [W:0] v);
      return (v[W] != v[W-1]) ? {v[W], {(W-1){~v[W]}}} : v[W-1:0];
   endfunction

   assign x_rnd_full = {x[WI-1], x} + HALF;
   assign y_rnd_full = {y[WI-1], y} + HALF;
   assign x_rnd      = (W+1)'(x_rnd_full >>> GUARD);
   assign y_rnd      = (W+1)'(y_rnd_full >>> GUARD);
   assign x_sat      = sat_w(x_rnd);
   assign y_sat      = sat_w(y_rnd);
   assign sum_full   = {x_sat[W-1], x_sat} + {y_sat[W-1], y_sat};
   assign sum_sat    = sat_w(sum_full);
   assign sat_any    = (x_rnd[W] ^ x_rnd[W-1]) | (y_rnd[W] ^ y_rnd[W-1]) |
                       (sum_full[W] ^ sum_full[W-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         err_r   <= 1'b0;
         x_out   <= '0;
         y_out   <= '0;
         sum_out <= '0;
         mode_r  <= MODE_CIRC;
         rep     <= 1'b0;
         idx     <= '0;
         cnt     <= '0;
         x       <= '0;
         y       <= '0;
         z       <= '0;
`ifdef CORDIC_SAT_FLAG_EN
         sat     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_r <= mode;
                  x      <= (mode == MODE_HYP) ? x0_hyp : x0_circ;
                  y      <= '0;
                  z      <= {angle, {GUARD{1'b0}}};
                  idx    <= (mode == MODE_HYP) ? IW'(1) : '0;
                  rep    <= 1'b0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  err_r  <= ~in_range;
                  state  <= in_range ? S_RUN : S_FIN;
               end
            end
            S_RUN: begin
               x   <= x_step;
               y   <= y_step;
               z   <= z_step;
               cnt <= cnt + 1'b1;
               if (rep_now) begin
                  rep <= 1'b1;
               end else begin
                  rep <= 1'b0;
                  idx <= idx + 1'b1;
               end
               if (last_step)
                  state <= S_FIN;
            end
            S_FIN: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               err     <= err_r;
               x_out   <= err_r ? '0 : x_sat;
               y_out   <= err_r ? '0 : y_sat;
               sum_out <= err_r ? '0 : sum_sat;
`ifdef CORDIC_SAT_FLAG_EN
               sat     <= err_r ? 1'b0 : sat_any;
`endif
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifndef CORDIC_SAT_FLAG_EN
   logic unused_sat;
   assign unused_sat = sat_any;
`endif

endmodule

// File: tb/tb_cordic_engine.sv
// tb/tb_cordic_engine.sv - self-checking bench for cordic_engine against a real-math reference
module tb_cordic_engine;

   localparam int  W     = 16;
   localparam real SCALE = 8192.0;
   localparam real TOL   = 4.0;

   logic          clk = 1'b0;
   logic          rst, start, mode;
   logic [W-1:0]  angle;
   logic          busy, done, err;
   logic [W-1:0]  x_out, y_out, sum_out;
`ifdef CORDIC_SAT_FLAG_EN
   logic          sat;
`endif

   int passed = 0;
   int total  = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   cordic_engine #(.W(W), .ITER(14), .GUARD(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .mode    (mode),
      .angle   (angle),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .x_out   (x_out),
      .y_out   (y_out),
      .sum_out (sum_out)
`ifdef CORDIC_SAT_FLAG_EN
      ,
      .sat     (sat)
`endif
   );

   task automatic chk_eq(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic chk_tol(input string tag, input int obs, input real exp);
      real diff;
      diff = $itor(obs) - exp;
      total++;
      assert (diff <= TOL && diff >= -TOL) passed++;
      else $error("FAIL %s: observed %0d expected %0.2f within 4 LSB", tag, obs, exp);
   endtask

   // Reference: ideal functions of the angle, range rule, and schedule-derived latency
   function automatic void model(input logic m, input int a, output bit e,
                                 output real ex, output real ey, output real es,
                                 output int lat);
      real zr;
      e  = m ? (a > 8192 || a < -8192) : (a > 12288 || a < -12288);
      zr = $itor(a) / SCALE;
      ex = (m ? $cosh(zr) : $cos(zr)) * SCALE;
      ey = (m ? $sinh(zr) : $sin(zr)) * SCALE;
      es = ex + ey;
      if (es > 32767.0)  es = 32767.0;
      if (es < -32768.0) es = -32768.0;
      lat = e ? 1 : (m ? 17 : 15);
   endfunction

   task automatic run_check(input string tag, input logic m, input int a);
      int  lat, exp_lat;
      bit  e;
      real ex, ey, es;
      model(m, a, e, ex, ey, es, exp_lat);
      @(negedge clk);
      mode  = m;
      angle = 16'(a);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk_eq({tag, ".busy"}, busy, 1);
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk_eq({tag, ".lat"}, lat, exp_lat);
      chk_eq({tag, ".err"}, err, e);
      if (e) begin
         chk_eq({tag, ".x"}, $signed(x_out), 0);
         chk_eq({tag, ".y"}, $signed(y_out), 0);
         chk_eq({tag, ".sum"}, $signed(sum_out), 0);
      end else begin
         chk_tol({tag, ".x"}, int'($signed(x_out)), ex);
         chk_tol({tag, ".y"}, int'($signed(y_out)), ey);
         chk_tol({tag, ".sum"}, int'($signed(sum_out)), es);
      end
      @(posedge clk);
      #1;
      chk_eq({tag, ".done_pulse"}, done, 0);
      chk_eq({tag, ".busy_after"}, busy, 0);
   endtask

   initial begin
      int c0;
      logic m;
      int a;

      rst   = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      angle = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("reset.busy", busy, 0);
      chk_eq("reset.done", done, 0);
      chk_eq("reset.err", err, 0);
      chk_eq("reset.x", x_out, 0);
      chk_eq("reset.y", y_out, 0);
      chk_eq("reset.sum", sum_out, 0);
      @(negedge clk);
      rst = 1'b0;

      run_check("circ_0", 1'b0, 0);
      run_check("circ_pi6", 1'b0, 4289);
      run_check("hyp_1", 1'b1, 8192);
      run_check("hyp_m05", 1'b1, -4096);

      // Start pulses during busy and in the final cycle must not spawn a second result
      c0 = done_cnt;
      @(negedge clk);
      mode  = 1'b0;
      angle = 16'(1000);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk_eq("hs.busy", busy, 1);
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk_eq("hs.done_at_15", done, 1);
      repeat (40) @(negedge clk);
      chk_eq("hs.single_done", done_cnt - c0, 1);
      chk_eq("hs.idle", busy, 0);

      // Reset part-way through a hyperbolic run
      @(negedge clk);
      mode  = 1'b1;
      angle = 16'(8192);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      c0 = done_cnt;
      chk_eq("rst.busy", busy, 0);
      chk_eq("rst.x", x_out, 0);
      chk_eq("rst.y", y_out, 0);
      chk_eq("rst.sum", sum_out, 0);
      repeat (30) @(negedge clk);
      chk_eq("rst.no_done", done_cnt - c0, 0);
      run_check("after_rst", 1'b1, 8192);

      run_check("circ_2p0_err", 1'b0, 16384);
      run_check("hyp_8193_err", 1'b1, 8193);
      run_check("circ_edge_pos", 1'b0, 12288);
      run_check("circ_edge_over", 1'b0, -12289);
      run_check("hyp_edge_neg", 1'b1, -8192);
      run_check("circ_min_neg", 1'b0, -32768);

      for (int k = 0; k < 24; k++) begin
         m = 1'($urandom_range(0, 1));
         if (m)
            a = int'($urandom_range(0, 18022)) - 9011;
         else
            a = int'($urandom_range(0, 26214)) - 13107;
         run_check($sformatf("rand%0d", k), m, a);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
